// File: rtl/uart_alu_sequencer.sv
//==============================================================================
// Module      : uart_alu_sequencer
// Description : Byte-level sequencer between a UART and a combinational ALU.
//               Three received bytes form one frame (operand A, operand B,
//               op code). The sequencer presents them to the ALU, registers
//               the result and hands it to the UART transmitter. A partial
//               frame is abandoned when the gap between two of its bytes
//               reaches TIMEOUT cycles. Bytes received while a result is
//               being produced or sent are dropped and flagged.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   i_clk         in   1        system clock
//   i_reset       in   1        asynchronous, active-low reset
//   i_rx_done     in   1        1-cycle pulse: i_rx_data is valid
//   i_rx_data     in   NB_DATA  received byte
//   i_tx_done     in   1        1-cycle pulse: transmitter finished stop bit
//   i_alu_result  in   NB_DATA  combinational ALU output
//   o_data_a      out  NB_DATA  operand A, held until the next frame's A
//   o_data_b      out  NB_DATA  operand B
//   o_op          out  NB_CODE  ALU op code (low bits of the third byte)
//   o_tx_start    out  1        1-cycle pulse: transmit o_tx_data
//   o_tx_data     out  NB_DATA  registered ALU result
//   o_busy        out  1        high whenever the FSM is not in IDLE
//   o_timeout     out  1        1-cycle pulse: partial frame abandoned
//   o_overrun     out  1        1-cycle pulse: byte dropped while busy
//==============================================================================
`default_nettype none

module uart_alu_sequencer #(
  parameter int NB_DATA  = 8,
  parameter int NB_CODE  = 6,
  parameter int NB_STATE = 3,
  parameter int NB_TIMER = 22,
  parameter int TIMEOUT  = 2000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_CODE-1:0] o_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_overrun
);

  typedef enum logic [NB_STATE-1:0] {
    IDLE    = NB_STATE'(0),
    GET_B   = NB_STATE'(1),
    GET_OP  = NB_STATE'(2),
    EXEC    = NB_STATE'(3),
    SEND    = NB_STATE'(4),
    WAIT_TX = NB_STATE'(5)
  } state_t;

  // Timer value on the last cycle a byte is still accepted; a byte arriving
  // on this cycle wins over the expiry.
  localparam logic [NB_TIMER-1:0] c_TIMER_LAST = NB_TIMER'(TIMEOUT - 1);
  localparam logic [NB_TIMER-1:0] c_TIMER_MAX  = '1;

  state_t              r_state;
  logic [NB_TIMER-1:0] r_timer;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_op       <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      // Pulse outputs default low so each assertion lasts one cycle.
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;

      case (r_state)
        IDLE: begin
          if (i_rx_done) begin
            o_data_a <= i_rx_data;
            r_timer  <= '0;
            o_busy   <= 1'b1;
            r_state  <= GET_B;
          end
        end

        GET_B: begin
          if (i_rx_done) begin
            o_data_b <= i_rx_data;
            r_timer  <= '0;
            r_state  <= GET_OP;
          end else if (r_timer == c_TIMER_LAST) begin
            // Operands already latched are kept; only the frame is dropped.
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            r_state   <= IDLE;
          end else if (r_timer != c_TIMER_MAX) begin
            r_timer <= r_timer + NB_TIMER'(1);
          end
        end

        GET_OP: begin
          if (i_rx_done) begin
            o_op    <= i_rx_data[NB_CODE-1:0];
            r_state <= EXEC;
          end else if (r_timer == c_TIMER_LAST) begin
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            r_state   <= IDLE;
          end else if (r_timer != c_TIMER_MAX) begin
            r_timer <= r_timer + NB_TIMER'(1);
          end
        end

        EXEC: begin
          // Operands have been stable for a full cycle, so the ALU output
          // is settled here. The start pulse is raised for the SEND cycle.
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          o_overrun  <= i_rx_done;
          r_state    <= SEND;
        end

        SEND: begin
          o_overrun <= i_rx_done;
          r_state   <= WAIT_TX;
        end

        WAIT_TX: begin
          // A byte coinciding with tx_done is still dropped, never used as A.
          o_overrun <= i_rx_done;
          if (i_tx_done) begin
            o_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: begin
          o_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_alu_sequencer.sv
//==============================================================================
// Module      : tb_uart_alu_sequencer
// Description : Self-checking bench for uart_alu_sequencer with a small ALU
//               model, a UART transmitter responder and a result scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_alu_sequencer;

  localparam int NB_DATA = 8;
  localparam int NB_CODE = 6;
  localparam int TIMEOUT = 100;
  localparam int TX_LAT  = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               rx_done = 1'b0;
  logic [NB_DATA-1:0] rx_data = '0;
  logic               tx_done = 1'b0;
  logic [NB_DATA-1:0] alu_res;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_CODE-1:0] o_op;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_busy;
  logic               o_timeout;
  logic               o_overrun;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_ovr = 0;
  int n_tmo = 0;
  int tx_countdown = -1;
  logic [NB_DATA-1:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] res;
  } vec_t;
  vec_t tbl[11];

  uart_alu_sequencer #(
    .NB_DATA (NB_DATA),
    .NB_CODE (NB_CODE),
    .NB_STATE(3),
    .NB_TIMER(22),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_rx_done   (rx_done),
    .i_rx_data   (rx_data),
    .i_tx_done   (tx_done),
    .i_alu_result(alu_res),
    .o_data_a    (o_data_a),
    .o_data_b    (o_data_b),
    .o_op        (o_op),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout),
    .o_overrun   (o_overrun)
  );

  always #5 clk = ~clk;

  // Combinational ALU model.
  always_comb begin
    alu_res = '0;
    case (o_op)
      6'h20: alu_res = o_data_a + o_data_b;
      6'h22: alu_res = o_data_a - o_data_b;
      6'h24: alu_res = o_data_a & o_data_b;
      6'h25: alu_res = o_data_a | o_data_b;
      6'h26: alu_res = o_data_a ^ o_data_b;
      6'h27: alu_res = ~(o_data_a | o_data_b);
      6'h03: alu_res = $unsigned($signed(o_data_a) >>> o_data_b);
      6'h02: alu_res = o_data_a >> o_data_b;
      default: alu_res = '0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transmitter responder: tx_done pulse a fixed time after each start.
  always @(posedge clk) begin
    #1;
    tx_done = 1'b0;
    if (tx_countdown == 0) tx_done = 1'b1;
    if (tx_countdown >= 0) tx_countdown--;
    if (o_tx_start) tx_countdown = TX_LAT;
  end

  // Scoreboard and pulse counters.
  always @(negedge clk) begin
    if (o_tx_start) begin
      n_start++;
      if (exp_q.size() == 0) check("tx_unexpected", 64'd1, 64'd0);
      else check("tx_data", {56'd0, o_tx_data}, {56'd0, exp_q.pop_front()});
    end
    if (o_overrun) n_ovr++;
    if (o_timeout) n_tmo++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] all_outs();
    return {30'd0, o_data_a, o_data_b, o_op, o_tx_start, o_tx_data, o_busy, o_timeout, o_overrun};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Caller is at posedge+1; byte is sampled at the next rising edge.
  task automatic drive_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input logic [7:0] res);
    exp_q.push_back(res);
    drive_byte(a);
    drive_byte(b);
    drive_byte(op);
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (o_busy && g < 200) begin
      wait_cycles(1);
      g++;
    end
    check(name, {63'd0, o_busy}, 64'd0);
  endtask

  initial begin
    int base_start, base_ovr, base_tmo, k;

    tbl[0]  = '{8'h03, 8'h08, 8'h20, 8'h0B};
    tbl[1]  = '{8'h0F, 8'h01, 8'h22, 8'h0E};
    tbl[2]  = '{8'hFF, 8'h02, 8'h20, 8'h01};
    tbl[3]  = '{8'h01, 8'h02, 8'h22, 8'hFF};
    tbl[4]  = '{8'hF0, 8'h3C, 8'h24, 8'h30};
    tbl[5]  = '{8'hF0, 8'h0F, 8'h25, 8'hFF};
    tbl[6]  = '{8'hAA, 8'hFF, 8'h26, 8'h55};
    tbl[7]  = '{8'h0F, 8'h30, 8'h27, 8'hC0};
    tbl[8]  = '{8'h80, 8'h02, 8'h03, 8'hE0};
    tbl[9]  = '{8'h80, 8'h02, 8'h02, 8'h20};
    tbl[10] = '{8'h03, 8'h08, 8'hE0, 8'h0B};

    // Reset state.
    wait_cycles(3);
    check("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Single frame with latency check.
    base_start = n_start;
    send_frame(8'h03, 8'h08, 8'h20, 8'h0B);
    check("start_in_exec", {63'd0, o_tx_start}, 64'd0);
    wait_cycles(1);
    check("start_n_plus_2", {63'd0, o_tx_start}, 64'd1);
    check("tx_data_first", {56'd0, o_tx_data}, 64'h0B);
    wait_cycles(1);
    check("start_one_cycle", {63'd0, o_tx_start}, 64'd0);
    check("busy_in_wait_tx", {63'd0, o_busy}, 64'd1);
    wait_idle("idle_after_first");
    check("start_count_first", 64'(n_start - base_start), 64'd1);

    // Table of frames, each started as soon as the previous one finishes.
    base_start = n_start;
    base_ovr   = n_ovr;
    base_tmo   = n_tmo;
    for (int i = 0; i < 11; i++) begin
      send_frame(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].res);
      check($sformatf("operands_%0d", i), {40'd0, o_data_a, o_data_b, 2'b00, o_op},
            {40'd0, tbl[i].a, tbl[i].b, 2'b00, tbl[i].op[5:0]});
      wait_idle($sformatf("idle_%0d", i));
    end
    check("table_starts", 64'(n_start - base_start), 64'd11);
    check("table_no_overrun", 64'(n_ovr - base_ovr), 64'd0);
    check("table_no_timeout", 64'(n_tmo - base_tmo), 64'd0);

    // Inter-byte timeout: pulse 100 edges after the byte is sampled.
    base_tmo = n_tmo;
    drive_byte(8'h05);
    k = 0;
    while (!o_timeout && k < 150) begin
      wait_cycles(1);
      k++;
    end
    check("timeout_delay", 64'(k), 64'd100);
    check("timeout_idle", {63'd0, o_busy}, 64'd0);
    check("timeout_keeps_a", {56'd0, o_data_a}, 64'h05);
    wait_cycles(1);
    check("timeout_count", 64'(n_tmo - base_tmo), 64'd1);
    send_frame(8'h10, 8'h20, 8'h20, 8'h30);
    wait_idle("idle_after_timeout_frame");

    // Byte on the expiry cycle wins.
    base_tmo = n_tmo;
    drive_byte(8'h07);
    wait_cycles(99);
    drive_byte(8'h09);
    check("expiry_byte_busy", {63'd0, o_busy}, 64'd1);
    check("expiry_byte_b", {56'd0, o_data_b}, 64'h09);
    exp_q.push_back(8'h10);
    drive_byte(8'h20);
    wait_idle("idle_after_expiry_frame");
    check("expiry_no_timeout", 64'(n_tmo - base_tmo), 64'd0);

    // Overrun during WAIT_TX.
    base_ovr = n_ovr;
    send_frame(8'h03, 8'h08, 8'h20, 8'h0B);
    wait_cycles(2);
    check("wait_tx_busy", {63'd0, o_busy}, 64'd1);
    drive_byte(8'h55);
    check("overrun_pulse", {63'd0, o_overrun}, 64'd1);
    wait_cycles(1);
    check("overrun_one_cycle", {63'd0, o_overrun}, 64'd0);
    wait_idle("idle_after_overrun");
    check("overrun_count", 64'(n_ovr - base_ovr), 64'd1);
    check("overrun_not_a", {56'd0, o_data_a}, 64'h03);

    // Byte coinciding with tx_done in WAIT_TX.
    send_frame(8'h0F, 8'h01, 8'h22, 8'h0E);
    k = 0;
    while (!o_tx_start && k < 20) begin
      wait_cycles(1);
      k++;
    end
    check("simul_start_seen", {63'd0, o_tx_start}, 64'd1);
    wait_cycles(TX_LAT + 1);
    drive_byte(8'hA5);
    check("simul_idle", {63'd0, o_busy}, 64'd0);
    check("simul_overrun", {63'd0, o_overrun}, 64'd1);
    wait_cycles(2);
    check("simul_not_a", {63'd0, o_busy} | {55'd0, o_data_a, 1'b0}, {55'd0, 8'h0F, 1'b0});

    // Asynchronous reset in GET_OP.
    drive_byte(8'h11);
    drive_byte(8'h22);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_get_op", all_outs(), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(2);
    send_frame(8'h06, 8'h07, 8'h20, 8'h0D);
    wait_idle("idle_after_reset_frame");

    // Reset during WAIT_TX; the late tx_done must be ignored.
    send_frame(8'h01, 8'h01, 8'h20, 8'h02);
    wait_cycles(3);
    base_start = n_start;
    #4;
    rst_n = 1'b0;
    #1;
    check("async_reset_wait_tx", all_outs(), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(15);
    check("late_tx_done_ignored", {63'd0, o_busy}, 64'd0);
    check("no_start_after_reset", 64'(n_start - base_start), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
